alu_issue: RTL and testbench

Issue/complete stage that drives the general-purpose ALU from the execute side of the pipeline. It accepts one decoded-format instruction plus register read data from fetch/decode, and presents registered operands and opcode to the ALU. It holds those operands for a per-opcode latency so that MUL and DIV close as multi-cycle paths. It then captures the ALU result and flags, resolves branches, and hands a writeback record to the register file over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/alu_issue_dec.sv | 58 +++++
 rtl/alu_issue.sv | 140 ++++++++++++++
 tb/tb_alu_issue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: opcodes, flag indices, issue-stage states.
// Also used by the ALU so both sides agree on opcode encoding.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'b00000,
    OP_ADD  = 5'b00010,
    OP_ADDI = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SUBI = 5'b00101,
    OP_MUL  = 5'b00110,
    OP_DIV  = 5'b01000,
    OP_AND  = 5'b01010,
    OP_ANDI = 5'b01011,
    OP_OR   = 5'b01100,
    OP_ORI  = 5'b01101,
    OP_NOT  = 5'b01110,
    OP_XOR  = 5'b10000,
    OP_XORI = 5'b10001,
    OP_BEQ  = 5'b10010,
    OP_BLT  = 5'b10011,
    OP_BGT  = 5'b10100,
    OP_BNE  = 5'b10101
  } opcode_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_t;

  function automatic logic [31:0] sext12(
    input logic [11:0] imm
  );
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Opcode decoder for the ALU issue stage.
// Purely combinational; branches are issued to the ALU as SUB.
module alu_issue_dec
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [4:0] alu_op,
  output logic       use_imm,
  output logic       zero_b,
  output logic       is_branch,
  output logic       writes,
  output logic [1:0] lat_class,
  output logic       illegal
);

  always_comb begin
    alu_op    = opcode;
    use_imm   = 1'b0;
    zero_b    = 1'b0;
    is_branch = 1'b0;
    writes    = 1'b0;
    lat_class = LAT_ONE;
    illegal   = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_XOR:
        writes = 1'b1;
      OP_ADDI, OP_SUBI, OP_ANDI,
      OP_ORI, OP_XORI: begin
        writes  = 1'b1;
        use_imm = 1'b1;
      end
      OP_NOT: begin
        writes = 1'b1;
        zero_b = 1'b1;
      end
      OP_MUL: begin
        writes    = 1'b1;
        lat_class = LAT_MUL;
      end
      OP_DIV: begin
        writes    = 1'b1;
        lat_class = LAT_DIV;
      end
      OP_BEQ, OP_BLT,
      OP_BGT, OP_BNE: begin
        is_branch = 1'b1;
        alu_op    = OP_SUB;
      end
      default: begin
        illegal = 1'b1;
        alu_op  = OP_NOP;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue/complete stage: registers operands, holds them for the
// opcode latency, captures the result and hands it to writeback.
module alu_issue
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, lat;
  logic [4:0]     op_q;
  logic [4:0]     dec_op;
  logic           use_imm, zero_b;
  logic           is_branch, writes, dec_ill;
  logic [1:0]     lat_class;
  logic           accept, last;
  logic [31:0]    imm;
  logic           unused_fields;

  assign unused_fields = ^{instr[21:12], is_branch};

  alu_issue_dec u_dec (
    .opcode    (instr[31:27]),
    .alu_op    (dec_op),
    .use_imm   (use_imm),
    .zero_b    (zero_b),
    .is_branch (is_branch),
    .writes    (writes),
    .lat_class (lat_class),
    .illegal   (dec_ill)
  );

  assign imm         = sext12(instr[11:0]);
  assign instr_ready = (state == S_IDLE) && !rst;
  assign accept      = instr_ready && instr_valid && !dec_ill;
  assign last        = (state == S_EXEC) && (cnt == CW'(1));
  assign wb_valid    = (state == S_DONE);

  always_comb begin
    lat = CW'(1);
    case (lat_class)
      LAT_MUL: lat = CW'(MUL_CYCLES);
      LAT_DIV: lat = CW'(DIV_CYCLES);
      default: lat = CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_EXEC;
      S_EXEC: if (last) state_nx = S_DONE;
      S_DONE: if (wb_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  function automatic logic resolve(
    input logic [4:0] op,
    input logic [1:0] f
  );
    case (op)
      OP_BEQ:  return f[FLAG_Z];
      OP_BNE:  return !f[FLAG_Z];
      OP_BLT:  return f[FLAG_N];
      OP_BGT:  return !f[FLAG_N] && !f[FLAG_Z];
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      op_q      <= '0;
      cnt       <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_we     <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= instr_ready && instr_valid && dec_ill;
      if (accept) begin
        alu_op    <= dec_op;
        alu_a     <= rs1_data;
        alu_b     <= zero_b  ? 32'd0 :
                     use_imm ? imm : rs2_data;
        op_q      <= instr[31:27];
        cnt       <= lat;
        wb_rd     <= instr[26:22];
        wb_we     <= writes && (instr[26:22] != 5'd0);
        br_taken  <= 1'b0;
        br_target <= pc + imm;
      end
      if (state == S_EXEC) begin
        cnt <= cnt - CW'(1);
        if (last) begin
          wb_data  <= alu_result;
          br_taken <= resolve(op_q, alu_flags);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small ALU stub on the ALU port.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_issue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data, rs2_data, pc;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_flags;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we, br_taken;
  logic [31:0] br_target;
  logic        illegal;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_issue #(.MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .pc          (pc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .illegal     (illegal)
  );

  always_comb begin
    alu_result = alu_a ^ alu_b;
    case (alu_op)
      OP_ADD, OP_ADDI: alu_result = alu_a + alu_b;
      OP_SUB, OP_SUBI: alu_result = alu_a - alu_b;
      OP_MUL: alu_result = alu_a * alu_b;
      OP_DIV: alu_result = (alu_b != 0) ? alu_a / alu_b : '1;
      default: ;
    endcase
    alu_flags = {alu_result[31], alu_result == 32'd0};
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [4:0] op, input logic [4:0] rd,
    input logic [11:0] imm
  );
    return {op, rd, 5'd1, 5'd2, imm};
  endfunction

  task automatic issue(
    input logic [31:0] ins, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] p
  );
    instr_valid = 1'b1;
    instr = ins;
    rs1_data = a;
    rs2_data = b;
    pc = p;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    rs1_data = '0;
    rs2_data = '0;
    pc = '0;
    wb_ready = 1'b0;
    step();
    step();
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", {27'd0, alu_op}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_ready", {31'd0, instr_ready}, 0);
    chk("rst_flags", {br_taken, wb_we, illegal}, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", {31'd0, instr_ready}, 1);

    // ADDI rd=3, 5 + sext(0xFFF)
    issue(mk(OP_ADDI, 5'd3, 12'hFFF), 5, 99, 0);
    chk("addi_alu_b", alu_b, 32'hFFFF_FFFF);
    chk("addi_alu_a", alu_a, 5);
    chk("addi_op", {27'd0, alu_op}, 32'd3);
    chk("addi_c1_wbv", {31'd0, wb_valid}, 0);
    chk("addi_c1_rdy", {31'd0, instr_ready}, 0);
    step();
    chk("addi_wbv", {31'd0, wb_valid}, 1);
    chk("addi_data", wb_data, 4);
    chk("addi_rd", {27'd0, wb_rd}, 3);
    chk("addi_we", {31'd0, wb_we}, 1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("addi_post_wbv", {31'd0, wb_valid}, 0);
    chk("addi_post_rdy", {31'd0, instr_ready}, 1);

    // DIV 100/7, eight EXEC cycles
    issue(mk(OP_DIV, 5'd6, 12'h0), 100, 7, 0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("div_a_c%0d", i), alu_a, 100);
      chk($sformatf("div_b_c%0d", i), alu_b, 7);
      chk($sformatf("div_op_c%0d", i), {27'd0, alu_op}, 8);
      chk($sformatf("div_rdy_c%0d", i), {31'd0, instr_ready}, 0);
      chk($sformatf("div_wbv_c%0d", i), {31'd0, wb_valid}, 0);
      step();
    end
    chk("div_wbv", {31'd0, wb_valid}, 1);
    chk("div_data", wb_data, 14);
    chk("div_rdy9", {31'd0, instr_ready}, 0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // BLT 3 < 7 taken, target 0x100 + 0x10
    issue(mk(OP_BLT, 5'd9, 12'h010), 3, 7, 32'h100);
    chk("blt_op", {27'd0, alu_op}, 32'd4);
    chk("blt_b", alu_b, 7);
    step();
    chk("blt_wbv", {31'd0, wb_valid}, 1);
    chk("blt_taken", {31'd0, br_taken}, 1);
    chk("blt_target", br_target, 32'h110);
    chk("blt_we", {31'd0, wb_we}, 0);
    chk("blt_data", wb_data, 32'hFFFF_FFFC);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // BGT equal operands, negative immediate
    issue(mk(OP_BGT, 5'd2, 12'h800), 5, 5, 32'h10);
    step();
    chk("bgt_taken", {31'd0, br_taken}, 0);
    chk("bgt_target", br_target, 32'hFFFF_F810);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Undefined opcode
    issue({5'b11111, 27'd0}, 1, 2, 0);
    chk("ill_pulse", {31'd0, illegal}, 1);
    chk("ill_rdy", {31'd0, instr_ready}, 1);
    chk("ill_wbv", {31'd0, wb_valid}, 0);
    step();
    chk("ill_off", {31'd0, illegal}, 0);
    chk("ill_wbv2", {31'd0, wb_valid}, 0);
    chk("ill_op", {27'd0, alu_op}, 32'd4);

    // SUB with back-pressure; target wraps
    issue(mk(OP_SUB, 5'd4, 12'h020), 10, 3, 32'hFFFF_FFF0);
    step();
    instr_valid = 1'b1;
    instr = mk(OP_ADD, 5'd5, 12'h0);
    rs1_data = 1;
    rs2_data = 1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_wbv%0d", i), {31'd0, wb_valid}, 1);
      chk($sformatf("bp_data%0d", i), wb_data, 7);
      chk($sformatf("bp_rd%0d", i), {27'd0, wb_rd}, 4);
      chk($sformatf("bp_tgt%0d", i), br_target, 32'h10);
      chk($sformatf("bp_rdy%0d", i), {31'd0, instr_ready}, 0);
      step();
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("bp_idle_rdy", {31'd0, instr_ready}, 1);
    chk("bp_idle_op", {27'd0, alu_op}, 32'd4);
    step();
    instr_valid = 1'b0;
    chk("bp_next_op", {27'd0, alu_op}, 32'd2);
    step();
    chk("bp_next_data", wb_data, 2);
    chk("bp_next_rd", {27'd0, wb_rd}, 5);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Reset during MUL EXEC cycle 1
    issue(mk(OP_MUL, 5'd7, 12'h0), 6, 7, 32'h40);
    chk("mul_op", {27'd0, alu_op}, 32'd6);
    rst = 1'b1;
    step();
    chk("mrst_a", alu_a, 0);
    chk("mrst_b", alu_b, 0);
    chk("mrst_op", {27'd0, alu_op}, 0);
    chk("mrst_wb", {wb_data[27:0], wb_rd}, 0);
    chk("mrst_tgt", br_target, 0);
    chk("mrst_bits", {wb_valid, wb_we, br_taken, illegal}, 0);
    // Reset with a valid record present: not accepted
    instr_valid = 1'b1;
    instr = mk(OP_ADD, 5'd8, 12'h0);
    step();
    instr_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("rstv_op", {27'd0, alu_op}, 0);
    step();
    chk("mrst_nowb", {31'd0, wb_valid}, 0);
    chk("mrst_rdy", {31'd0, instr_ready}, 1);

    // Fresh ADD after reset, zero destination
    issue(mk(OP_ADD, 5'd0, 12'h0), 2, 3, 0);
    step();
    chk("add_wbv", {31'd0, wb_valid}, 1);
    chk("add_data", wb_data, 5);
    chk("add_we_rd0", {31'd0, wb_we}, 0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("add_done", {31'd0, wb_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
